// File: rtl/svm_pkg.sv
// Shared SVM accelerator constants: image/SV geometry, producer FSM encoding,
// and the 8.8 sign-magnitude kernel field layout.
package svm_pkg;

  localparam int unsigned XLEN_PIXEL    = 8;
  localparam int unsigned NUM_OF_PIXELS = 784;
  localparam int unsigned NUM_OF_SV     = 10;

  // 8.8 sign-magnitude kernel word
  localparam int unsigned KERN_W        = 2 * XLEN_PIXEL;
  localparam int unsigned KERN_SIGN_BIT = KERN_W - 1;
  localparam int unsigned KERN_MAG_W    = KERN_W - 1;
  localparam int unsigned KERN_FRAC_W   = XLEN_PIXEL;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StPack,
    StIssue,
    StDone
  } state_e;

endpackage

// File: rtl/kernel_vector_gen_if.sv
// Pixel stream, SV memory read port and kernel vector bus of kernel_vector_gen.
// master = kernel_vector_gen side, slave = surrounding pixel source / SV memory / consumer.
interface kernel_vector_gen_if #(
  parameter int unsigned XLEN_PIXEL    = svm_pkg::XLEN_PIXEL,
  parameter int unsigned NUM_OF_PIXELS = svm_pkg::NUM_OF_PIXELS,
  parameter int unsigned NUM_OF_SV     = svm_pkg::NUM_OF_SV,
  parameter int unsigned ADDR_W        = $clog2(NUM_OF_PIXELS),
  parameter int unsigned IDX_W         = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1
);

  logic                                pix_valid;
  logic                                pix_ready;
  logic [XLEN_PIXEL-1:0]               pix_data;
  logic                                sv_rd_en;
  logic [ADDR_W-1:0]                   sv_rd_addr;
  logic [XLEN_PIXEL*NUM_OF_SV-1:0]     sv_rd_data;
  logic [2*XLEN_PIXEL*NUM_OF_SV-1:0]   kernel_out;
  logic                                decision_funct_en;
  logic [IDX_W-1:0]                    sv_idx;

  modport master (
    input  pix_valid, pix_data, sv_rd_data,
    output pix_ready, sv_rd_en, sv_rd_addr, kernel_out, decision_funct_en, sv_idx
  );

  modport slave (
    output pix_valid, pix_data, sv_rd_data,
    input  pix_ready, sv_rd_en, sv_rd_addr, kernel_out, decision_funct_en, sv_idx
  );

endinterface

// File: rtl/kernel_vector_gen_mac_lane.sv
// One support-vector lane: unsigned pixel x SV-pixel MAC into a Q10.16 accumulator,
// then a saturating truncation to 8.8 sign-magnitude held in a register.
module mac_lane #(
  parameter int unsigned XLEN  = svm_pkg::XLEN_PIXEL,
  parameter int unsigned ACC_W = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [XLEN-1:0]   pix,
  input  logic [XLEN-1:0]   sv,
  input  logic              pack,
  output logic [2*XLEN-1:0] kernel
);

  localparam int unsigned ProdW  = 2 * XLEN;
  localparam int unsigned MagW   = 2 * XLEN - 1;
  localparam int unsigned MagLsb = XLEN;
  localparam int unsigned SatLsb = MagLsb + MagW;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ProdW-1:0]  prod;
  logic [2*XLEN-1:0] kernel_q, kernel_d;
  logic [MagW-1:0]   mag;

  always_comb begin
    prod  = ProdW'(pix) * ProdW'(sv);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Any integer bit above the 7-bit 8.8 range forces full-scale magnitude.
  always_comb begin
    mag      = (|acc_q[ACC_W-1:SatLsb]) ? {MagW{1'b1}} : acc_q[SatLsb-1:MagLsb];
    kernel_d = pack ? {1'b0, mag} : kernel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      kernel_q <= '0;
    end else begin
      acc_q    <= acc_d;
      kernel_q <= kernel_d;
    end
  end

  assign kernel = kernel_q;

endmodule

// File: rtl/kernel_vector_gen.sv
// Streams one image, accumulates linear kernels against NUM_OF_SV support vectors in
// parallel, then presents the packed vector for NUM_OF_SV decision-function cycles.
module kernel_vector_gen #(
  parameter int unsigned XLEN_PIXEL    = svm_pkg::XLEN_PIXEL,
  parameter int unsigned NUM_OF_PIXELS = svm_pkg::NUM_OF_PIXELS,
  parameter int unsigned NUM_OF_SV     = svm_pkg::NUM_OF_SV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  kernel_vector_gen_if.master  bus
);

  import svm_pkg::*;

  localparam int unsigned ADDR_W = $clog2(NUM_OF_PIXELS);
  localparam int unsigned ACC_W  = 2 * XLEN_PIXEL + ADDR_W;
  localparam int unsigned IDX_W  = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [XLEN_PIXEL-1:0]  pix_q;
  logic                   mac_en_q;
  logic                   pix_ready;
  logic                   hs;
  logic                   last_pix;
  logic                   last_idx;
  logic                   mac_clr;
  logic                   mac_pack;
  logic [2*XLEN_PIXEL*NUM_OF_SV-1:0] kernel;

  assign pix_ready = (state_q == StAccum);
  assign hs        = bus.pix_valid & pix_ready;
  assign last_pix  = (cnt_q == ADDR_W'(NUM_OF_PIXELS - 1));
  assign last_idx  = (idx_q == IDX_W'(NUM_OF_SV - 1));
  assign mac_clr   = (state_q == StIdle) & start;
  assign mac_pack  = (state_q == StPack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (hs && last_pix) state_d = StDrain;
      StDrain: state_d = StPack;
      StPack:  state_d = StIssue;
      StIssue: if (last_idx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mac_clr) begin
      cnt_d = '0;
    end else if (hs) begin
      cnt_d = cnt_q + 1'b1;
    end
    idx_d = (state_q == StIssue) ? idx_q + 1'b1 : '0;
  end

  // The multiply for a pixel happens the cycle after its handshake, once SV data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      mac_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mac_en_q <= hs;
      if (hs) begin
        pix_q <= bus.pix_data;
      end
    end
  end

  always_comb begin
    bus.pix_ready         = pix_ready;
    bus.sv_rd_en          = hs;
    bus.sv_rd_addr        = cnt_q;
    bus.decision_funct_en = (state_q == StIssue);
    bus.sv_idx            = (state_q == StIssue) ? idx_q : '0;
    bus.kernel_out        = kernel;
    busy                  = (state_q != StIdle);
    done                  = (state_q == StDone);
  end

  for (genvar k = 0; k < NUM_OF_SV; k++) begin : g_lane
    mac_lane #(
      .XLEN  (XLEN_PIXEL),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (mac_clr),
      .en     (mac_en_q),
      .pix    (pix_q),
      .sv     (bus.sv_rd_data[k*XLEN_PIXEL +: XLEN_PIXEL]),
      .pack   (mac_pack),
      .kernel (kernel[2*k*XLEN_PIXEL +: 2*XLEN_PIXEL])
    );
  end

endmodule

// File: tb/tb_kernel_vector_gen.sv
// Directed table-driven bench for kernel_vector_gen with an SV memory model and
// hand-written reset-abort sequence.
module tb_kernel_vector_gen;

  import svm_pkg::*;

  localparam int NPIX = NUM_OF_PIXELS;
  localparam int NSV  = NUM_OF_SV;
  localparam int XL   = XLEN_PIXEL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  kernel_vector_gen_if bus ();

  kernel_vector_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [XL-1:0] pix_mem [NPIX];
  logic [XL-1:0] sv_mem  [NSV][NPIX];

  // SV memory: one-cycle read latency
  always @(posedge clk) begin
    if (bus.sv_rd_en) begin
      for (int k = 0; k < NSV; k++) begin
        bus.sv_rd_data[k*XL +: XL] <= sv_mem[k][bus.sv_rd_addr];
      end
    end
  end

  typedef struct {
    string      name;
    logic [7:0] pix_fill;
    logic [7:0] sv_fill;
    logic [7:0] sv_step;
    bit         ovr;
    logic [7:0] pix0;
    logic [7:0] sv00;
    bit         rnd;
    bit         inj;
    logic [15:0] exp0;
    logic [15:0] exp_base;
    logic [15:0] exp_step;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_lane(input vec_t v, input int k);
    return (k == 0) ? v.exp0 : v.exp_base + 16'(k) * v.exp_step;
  endfunction

  task automatic fill(input vec_t v);
    for (int i = 0; i < NPIX; i++) begin
      pix_mem[i] = v.pix_fill;
      for (int k = 0; k < NSV; k++) sv_mem[k][i] = v.sv_fill + 8'(k) * v.sv_step;
    end
    if (v.ovr) begin
      pix_mem[0]   = v.pix0;
      sv_mem[0][0] = v.sv00;
    end
  endtask

  task automatic run_image(input vec_t v);
    int c = 0;
    int acc_cnt = 0;
    int en_cnt = 0;
    int en_first = 0;
    int done_cyc = 0;
    int idx_err = 0;
    int addr_err = 0;
    int stab_err = 0;
    bit seen_done = 1'b0;
    logic [2*XL*NSV-1:0] k_at_en = '0;
    fill(v);
    @(negedge clk);
    start = 1'b1;
    bus.pix_valid = 1'b0;
    while (!seen_done && c < 4000) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (v.inj && (c == 100 || (en_first != 0 && c == en_first + 3))) start = 1'b1;
      if (acc_cnt < NPIX) begin
        bus.pix_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.pix_data  = pix_mem[acc_cnt];
      end else begin
        bus.pix_valid = 1'b0;
      end
      #1;
      if (bus.sv_rd_en) begin
        if (int'(bus.sv_rd_addr) != acc_cnt) addr_err++;
        acc_cnt++;
      end
      if (bus.decision_funct_en) begin
        if (en_cnt == 0) begin
          en_first = c;
          k_at_en  = bus.kernel_out;
        end else if (bus.kernel_out !== k_at_en) begin
          stab_err++;
        end
        if (int'(bus.sv_idx) != en_cnt) idx_err++;
        en_cnt++;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = c;
      end
    end
    start = 1'b0;
    chk({v.name, "_done_seen"}, 32'(seen_done), 32'd1);
    chk({v.name, "_accepted"}, 32'(acc_cnt), 32'(NPIX));
    chk({v.name, "_addr_seq"}, 32'(addr_err), 32'd0);
    chk({v.name, "_en_len"}, 32'(en_cnt), 32'(NSV));
    chk({v.name, "_sv_idx"}, 32'(idx_err), 32'd0);
    chk({v.name, "_k_stable"}, 32'(stab_err), 32'd0);
    chk({v.name, "_done_after_en"}, 32'(done_cyc), 32'(en_first + NSV));
    if (!v.rnd) begin
      chk({v.name, "_en_cycle"}, 32'(en_first), 32'd787);
      chk({v.name, "_done_cycle"}, 32'(done_cyc), 32'd797);
    end
    for (int k = 0; k < NSV; k++) begin
      chk($sformatf("%s_lane%0d", v.name, k), 32'(k_at_en[2*k*XL +: 2*XL]), 32'(exp_lane(v, k)));
    end
    @(negedge clk);
    chk({v.name, "_idle_after"}, {29'd0, done, busy, bus.decision_funct_en}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_kernel"}, 32'(|bus.kernel_out), 32'd0);
    chk({tag, "_ctrl"},
        {26'd0, bus.decision_funct_en, done, bus.pix_ready, bus.sv_rd_en, busy, 1'b0}, 32'd0);
    chk({tag, "_sv_idx"}, 32'(bus.sv_idx), 32'd0);
  endtask

  initial begin
    int en_hi;
    // name, pix, sv, sv_step, ovr, pix0, sv00, rnd, inj, exp0, exp_base, exp_step
    vecs[0] = '{"all_ff",   8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0,
                16'h7FFF, 16'h7FFF, 16'h0000};
    vecs[1] = '{"zeros",    8'h00, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0,
                16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{"half",     8'h00, 8'h00, 8'h00, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0,
                16'h0040, 16'h0000, 16'h0000};
    vecs[3] = '{"trunc",    8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0,
                16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{"ramp",     8'h10, 8'h10, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0,
                16'h0310, 16'h0310, 16'h0031};
    vecs[5] = '{"high",     8'h20, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0,
                16'h619E, 16'h619E, 16'h0000};
    vecs[6] = '{"ramp_rnd", 8'h10, 8'h10, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0,
                16'h0310, 16'h0310, 16'h0031};
    vecs[7] = '{"ramp_inj", 8'h10, 8'h10, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1,
                16'h0310, 16'h0310, 16'h0031};

    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_image(vecs[i]);

    // Abort at pixel 400 with kernel_out still holding the previous (nonzero) result.
    fill(vecs[5]);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix_mem[c-1];
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    en_hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.decision_funct_en || done) en_hi++;
    end
    chk("abort_no_en", 32'(en_hi), 32'd0);
    bus.pix_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_image(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
